// File: rtl/axis_rr_arbiter.sv
// Round-robin, packet-locked arbiter that shares one AXI4-Stream output
// between NUM_SRC sources. The granted index is forwarded on m_axis_tid.
// No data is stored: the granted source is passed straight through, and
// backpressure reaches only that source.
module axis_rr_arbiter #(
    parameter int NUM_SRC  = 4,
    parameter int DATA_W   = 8,
    parameter int ID_W     = 2,
    parameter int PKT_MODE = 1
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]        s_axis_tvalid,
    input  logic [NUM_SRC-1:0]        s_axis_tlast,
    output logic [NUM_SRC-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    output logic [ID_W-1:0]           m_axis_tid,
    input  logic                      m_axis_tready,
    output logic                      busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [ID_W-1:0] grant_reg, grant_next;
    logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;

    logic [DATA_W-1:0] src_data [NUM_SRC];
    logic              found;
    logic [ID_W-1:0]   winner;
    logic [ID_W:0]     cand;
    logic              release_beat;

    // Per-source data slices and ready. Ready depends only on the held
    // grant and the consumer's ready, never on any source's valid.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign src_data[gi]      = s_axis_tdata[gi*DATA_W +: DATA_W];
        assign s_axis_tready[gi] = (state_reg == LOCKED) &&
                                   (grant_reg == ID_W'(gi)) && m_axis_tready;
    end

    // Rotating search: first valid source starting at rr_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_SRC)) begin
                cand = cand - (ID_W+1)'(NUM_SRC);
            end
            if (!found && s_axis_tvalid[cand[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[ID_W-1:0];
            end
        end
    end

    // A handshake frees the output at tlast, or on every beat when
    // packet locking is disabled.
    assign release_beat = (state_reg == LOCKED) && m_axis_tvalid && m_axis_tready &&
                          ((PKT_MODE == 0) || m_axis_tlast);

    // State, grant and pointer registers; reset aborts any packet in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Next-state: grant the search winner from IDLE, return to IDLE on
    // release and move the pointer just past the released source.
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    grant_next = winner;
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (release_beat) begin
                    state_next  = IDLE;
                    rr_ptr_next = (grant_reg == ID_W'(NUM_SRC - 1)) ? '0 : grant_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output mux: all zero in IDLE, pass-through of the granted source when LOCKED.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tid    = '0;
        busy          = 1'b0;
        if (state_reg == LOCKED) begin
            m_axis_tvalid = s_axis_tvalid[grant_reg];
            m_axis_tdata  = src_data[grant_reg];
            m_axis_tlast  = s_axis_tlast[grant_reg];
            m_axis_tid    = grant_reg;
            busy          = 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: a packet-locked instance and a beat-interleaving
// instance share the same stimulus and are compared every cycle against a
// queue/ownership reference model, with directed scenarios followed by a
// randomized run.
module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]  s_tvalid;
    logic [N-1:0]  s_tlast;
    logic          m_tready;

    logic [N-1:0]  tready0, tready1;
    logic [DW-1:0] tdata0, tdata1;
    logic          tvalid0, tvalid1, tlast0, tlast1, busy0, busy1;
    logic [IW-1:0] tid0, tid1;

    always #10 aclk = ~aclk;

    axis_rr_arbiter #(.NUM_SRC(N), .DATA_W(DW), .ID_W(IW), .PKT_MODE(1)) u_pkt (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(tready0),
        .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tlast(tlast0),
        .m_axis_tid(tid0), .m_axis_tready(m_tready), .busy(busy0)
    );

    axis_rr_arbiter #(.NUM_SRC(N), .DATA_W(DW), .ID_W(IW), .PKT_MODE(0)) u_beat (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(tready1),
        .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tlast(tlast1),
        .m_axis_tid(tid1), .m_axis_tready(m_tready), .busy(busy1)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // Reference model: owning source per instance (-1 = none) and start of search.
    int owner [2];
    int ptr   [2];

    logic [N-1:0]  rdy_seen [2];
    logic [8:0]    srcq [N][$];        // {tlast, tdata} per queued beat
    logic [10:0]   log_word [2][$];    // {tlast, tid, tdata} of completed beats
    int            log_cyc  [2][$];
    logic [31:0]   snap0, snap1;
    bit            rand_mode = 1'b0;
    int            follow = 0;
    logic          plan_tready = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Layout: tready[3:0] tdata[11:4] tvalid[12] tlast[13] tid[15:14] busy[16]
    function automatic logic [31:0] pack_dut(int m);
        if (m == 0) return {15'd0, busy0, tid0, tlast0, tvalid0, tdata0, tready0};
        return {15'd0, busy1, tid1, tlast1, tvalid1, tdata1, tready1};
    endfunction

    function automatic logic [31:0] model_expect(int m);
        logic [31:0] e;
        int g;
        e = '0;
        if (owner[m] >= 0) begin
            g = owner[m];
            e[3:0]   = m_tready ? (4'b0001 << g) : 4'b0000;
            e[11:4]  = s_tdata[g*DW +: DW];
            e[12]    = s_tvalid[g];
            e[13]    = s_tlast[g];
            e[15:14] = g[1:0];
            e[16]    = 1'b1;
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            owner[m] = -1;
            ptr[m]   = 0;
        end
    endtask

    task automatic clear_logs();
        for (int m = 0; m < 2; m++) begin
            log_word[m].delete();
            log_cyc[m].delete();
        end
    endtask

    task automatic push_beat(input int i, input bit last, input logic [7:0] d);
        srcq[i].push_back({last, d});
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (rand_mode) begin
                s_tvalid[i] = ($urandom_range(0, 3) != 0);
                s_tlast[i]  = ($urandom_range(0, 2) == 0);
                s_tdata[i*DW +: DW] = 8'($urandom_range(0, 255));
            end else if (srcq[i].size() > 0) begin
                s_tvalid[i] = 1'b1;
                s_tlast[i]  = srcq[i][0][8];
                s_tdata[i*DW +: DW] = srcq[i][0][7:0];
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
                s_tdata[i*DW +: DW] = '0;
            end
        end
        m_tready = rand_mode ? ($urandom_range(0, 3) != 0) : plan_tready;
    endtask

    task automatic check_all();
        check_eq($sformatf("outs_pkt_c%0d", cyc), pack_dut(0), model_expect(0));
        check_eq($sformatf("outs_beat_c%0d", cyc), pack_dut(1), model_expect(1));
        snap0 = pack_dut(0);
        snap1 = pack_dut(1);
        rdy_seen[0] = tready0;
        rdy_seen[1] = tready1;
        if (tvalid0 && m_tready) begin
            log_word[0].push_back({tlast0, tid0, tdata0});
            log_cyc[0].push_back(cyc);
        end
        if (tvalid1 && m_tready) begin
            log_word[1].push_back({tlast1, tid1, tdata1});
            log_cyc[1].push_back(cyc);
        end
    endtask

    task automatic model_update();
        int pick;
        for (int m = 0; m < 2; m++) begin
            if (owner[m] < 0) begin
                pick = -1;
                for (int k = N - 1; k >= 0; k--) begin
                    if (s_tvalid[(ptr[m] + k) % N]) pick = (ptr[m] + k) % N;
                end
                if (pick >= 0) owner[m] = pick;
            end else if (s_tvalid[owner[m]] && m_tready && (s_tlast[owner[m]] || m == 1)) begin
                ptr[m]   = (owner[m] + 1) % N;
                owner[m] = -1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!rand_mode && s_tvalid[i] && rdy_seen[follow][i] && srcq[i].size() > 0)
                void'(srcq[i].pop_front());
        end
    endtask

    task automatic step();
        drive_inputs();
        #1;
        check_all();
        @(posedge aclk);
        model_update();
        @(negedge aclk);
        cyc++;
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) srcq[i].delete();
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b0;
        aresetn  = 1'b0;
        #1;
        check_eq("reset_pkt", pack_dut(0), 32'd0);
        check_eq("reset_beat", pack_dut(1), 32'd0);
        model_reset();
        clear_logs();
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic check_log(input string tag, input int m, input int k, input logic [10:0] exp);
        if (k < log_word[m].size()) check_eq(tag, 32'(log_word[m][k]), 32'(exp));
        else check_eq(tag, 32'hDEAD, 32'(exp));
    endtask

    initial begin
        logic [23:0] vtrace;
        model_reset();
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;

        // Two competing 3-beat packets, then the pointer picks source 3 next.
        do_reset();
        follow = 0; plan_tready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            push_beat(0, b == 2, 8'(8'h10 + b));
            push_beat(2, b == 2, 8'(8'h30 + b));
        end
        for (int s = 0; s < 8; s++) step();
        check_eq("t1_count", log_word[0].size(), 6);
        for (int b = 0; b < 3; b++) begin
            check_log($sformatf("t1_src0_b%0d", b), 0, b, {(b == 2), 2'd0, 8'(8'h10 + b)});
            check_log($sformatf("t1_src2_b%0d", b), 0, b + 3, {(b == 2), 2'd2, 8'(8'h30 + b)});
        end
        if (log_cyc[0].size() >= 4) check_eq("t1_bubble", log_cyc[0][3] - log_cyc[0][2], 2);
        else check_eq("t1_bubble", 0, 2);
        push_beat(0, 1'b1, 8'h50);
        push_beat(3, 1'b1, 8'h53);
        for (int s = 0; s < 4; s++) step();
        check_log("t1_ptr3_first", 0, 6, {1'b1, 2'd3, 8'h53});
        check_log("t1_ptr3_second", 0, 7, {1'b1, 2'd0, 8'h50});

        // All sources valid with single-beat packets: strict rotation, valid every other cycle.
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < N; i++) push_beat(i, 1'b1, 8'(8'h60 + i));
        vtrace = '0;
        for (int s = 0; s < 24; s++) begin
            step();
            vtrace[s] = snap0[12];
        end
        check_eq("t2_valid_pattern", 32'(vtrace), 32'hAAAAAA);
        for (int k = 0; k < 12; k++)
            check_log($sformatf("t2_rot%0d", k), 0, k, {1'b1, 2'(k % 4), 8'(8'h60 + k % 4)});

        // Stall mid-packet while another source asks: output holds, no switch.
        do_reset();
        for (int b = 0; b < 4; b++) push_beat(1, b == 3, 8'(8'h20 + b));
        for (int s = 0; s < 3; s++) step();
        plan_tready = 1'b0;
        push_beat(3, 1'b1, 8'h40);
        for (int s = 0; s < 3; s++) begin
            step();
            check_eq($sformatf("t3_hold_tid%0d", s), 32'(snap0[15:14]), 32'd1);
            check_eq($sformatf("t3_hold_data%0d", s), 32'(snap0[11:4]), 32'h22);
            check_eq($sformatf("t3_ready3_%0d", s), 32'(snap0[3]), 32'd0);
        end
        plan_tready = 1'b1;
        for (int s = 0; s < 4; s++) step();
        for (int b = 0; b < 4; b++)
            check_log($sformatf("t3_src1_b%0d", b), 0, b, {(b == 3), 2'd1, 8'(8'h20 + b)});
        check_log("t3_src3_after", 0, 4, {1'b1, 2'd3, 8'h40});

        // Beat interleaving on the non-locking instance.
        do_reset();
        follow = 1;
        push_beat(0, 1'b0, 8'h70); push_beat(0, 1'b1, 8'h71);
        push_beat(1, 1'b0, 8'h80); push_beat(1, 1'b1, 8'h81);
        for (int s = 0; s < 8; s++) step();
        check_log("t4_b0", 1, 0, {1'b0, 2'd0, 8'h70});
        check_log("t4_b1", 1, 1, {1'b0, 2'd1, 8'h80});
        check_log("t4_b2", 1, 2, {1'b1, 2'd0, 8'h71});
        check_log("t4_b3", 1, 3, {1'b1, 2'd1, 8'h81});
        follow = 0;

        // Asynchronous reset pulse while locked on source 2.
        do_reset();
        for (int b = 0; b < 3; b++) push_beat(2, b == 2, 8'(8'hC0 + b));
        step();
        step();
        push_beat(0, 1'b1, 8'h90);
        drive_inputs();
        #1;
        check_all();
        check_eq("t5_locked_before", 32'(snap0[16]), 32'd1);
        aresetn = 1'b0;
        #1;
        check_eq("t5_async_pkt", pack_dut(0), 32'd0);
        check_eq("t5_async_beat", pack_dut(1), 32'd0);
        model_reset();
        #6;
        aresetn = 1'b1;
        #1;
        check_all();
        @(posedge aclk);
        model_update();
        @(negedge aclk);
        cyc++;
        clear_logs();
        step();
        check_log("t5_grant0", 0, 0, {1'b1, 2'd0, 8'h90});

        // Single active source 3: re-grant after one bubble, pointer wraps to 0.
        do_reset();
        push_beat(3, 1'b0, 8'hA0); push_beat(3, 1'b1, 8'hA1);
        push_beat(3, 1'b0, 8'hA2); push_beat(3, 1'b1, 8'hA3);
        for (int s = 0; s < 6; s++) step();
        for (int b = 0; b < 4; b++)
            check_log($sformatf("t6_b%0d", b), 0, b, {(b % 2 == 1), 2'd3, 8'(8'hA0 + b)});
        if (log_cyc[0].size() >= 3) check_eq("t6_bubble", log_cyc[0][2] - log_cyc[0][1], 2);
        else check_eq("t6_bubble", 0, 2);
        push_beat(0, 1'b1, 8'hB0);
        push_beat(1, 1'b1, 8'hB1);
        for (int s = 0; s < 4; s++) step();
        check_log("t6_wrap0", 0, 4, {1'b1, 2'd0, 8'hB0});
        check_log("t6_wrap1", 0, 5, {1'b1, 2'd1, 8'hB1});

        // Randomized traffic checked cycle by cycle against the model.
        do_reset();
        rand_mode = 1'b1;
        for (int s = 0; s < 3000; s++) begin
            if (s % 700 == 699) do_reset();
            step();
        end
        rand_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
